// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with a one-byte valid/ready holding register
//
// Recovers bytes from an idle-high serial line (1 start, 8 data LSB first,
// 1 stop) and presents them one at a time to a consumer.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   rx_in      raw serial line, asynchronous to clk, idle high
//   rx_data    received byte, meaningful while rx_valid=1
//   rx_valid   holding register full
//   rx_ready   consumer takes the byte on a rising edge with rx_valid=1
//   busy       receiver is somewhere inside a frame (FSM not idle)
//   frame_err  one-cycle pulse when the stop bit is sampled low
//   overrun    one-cycle pulse when a good byte is dropped (register full)

module uart_rx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_IDLE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             byte_done;
  logic             stop_err;

  logic             rx_meta;
  logic             rx_s;
  logic             rx_s_prev;
  logic             rx_fall;

  // Two-flop synchronizer plus one history flop for edge detection. All
  // reset to the idle level so reset release never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta   <= 1'b1;
      rx_s      <= 1'b1;
      rx_s_prev <= 1'b1;
    end else begin
      rx_meta   <= rx_in;
      rx_s      <= rx_meta;
      rx_s_prev <= rx_s;
    end
  end

  assign rx_fall = rx_s_prev & ~rx_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    byte_done = 1'b0;
    stop_err  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (rx_fall) begin
          state_d = ST_START;
        end
      end

      // Check the start bit half a bit in; a high line here means a glitch.
      // Clearing the counter at this point moves all later samples to mid-bit.
      ST_START: begin
        if (cnt_q == CNT_MID) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = ST_IDLE;
          end else begin
            state_d   = ST_DATA;
            bit_idx_d = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d            = '0;
          shift_d[bit_idx_q] = rx_s;
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      // Returning to idle at the stop-bit midpoint leaves half a bit of
      // margin to catch a back-to-back start edge.
      ST_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            byte_done = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            stop_err = 1'b1;
            state_d  = ST_WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      // A held-low line (break) must not retrigger; wait for the idle level.
      ST_WAIT_IDLE: begin
        cnt_d = '0;
        if (rx_s) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy = (state_q != ST_IDLE);

  // Holding register. A full register being drained on the same edge can
  // accept the new byte; otherwise the new byte is dropped and flagged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= stop_err;
      overrun   <= 1'b0;
      if (byte_done) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shift_q;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx with a byte-level reference model

module tb_uart_rx;

  localparam int CPB       = 16;
  localparam int FRAME_CYC = 10 * CPB;
  // Edges from driving the start bit to the holding register update.
  localparam int LAT       = 2 + (CPB - 1) / 2 + 9 * CPB + 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_in = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       frame_err;
  logic       overrun;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_in    (rx_in),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .busy     (busy),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each complete frame becomes an event at the edge where
  // the holding register must react; the handshake rules are applied there.
  typedef struct {
    int         edge_no;
    logic [7:0] data;
    bit         good;
  } frame_t;

  frame_t     evq[$];
  int         edge_n = 0;
  logic [7:0] m_data = 8'h00;
  bit         m_valid = 1'b0;
  bit         m_ferr = 1'b0;
  bit         m_ovr = 1'b0;

  always @(posedge clk) begin : model
    frame_t ev;
    bit     done;
    edge_n++;
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
    done   = 1'b0;
    ev     = '{edge_no: 0, data: 8'h00, good: 1'b0};
    if (evq.size() > 0 && evq[0].edge_no == edge_n) begin
      ev   = evq.pop_front();
      done = 1'b1;
    end
    if (rst) begin
      m_valid = 1'b0;
      m_data  = 8'h00;
      evq.delete();
    end else if (done && ev.good) begin
      if (!m_valid || rx_ready) begin
        m_data  = ev.data;
        m_valid = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
    end else begin
      if (done) m_ferr = 1'b1;
      if (m_valid && rx_ready) m_valid = 1'b0;
    end
  end

  int valid_hi = 0;
  int ferr_cnt = 0;
  int ovr_cnt  = 0;
  int busy_cnt = 0;

  always @(negedge clk) begin
    if (rst) begin
      check("rst_rx_data", {24'h0, rx_data}, 32'h0);
      check("rst_rx_valid", {31'h0, rx_valid}, 32'h0);
      check("rst_busy", {31'h0, busy}, 32'h0);
      check("rst_frame_err", {31'h0, frame_err}, 32'h0);
      check("rst_overrun", {31'h0, overrun}, 32'h0);
    end else begin
      check("rx_data", {24'h0, rx_data}, {24'h0, m_data});
      check("rx_valid", {31'h0, rx_valid}, {31'h0, m_valid});
      check("frame_err", {31'h0, frame_err}, {31'h0, m_ferr});
      check("overrun", {31'h0, overrun}, {31'h0, m_ovr});
      if (rx_valid)  valid_hi++;
      if (frame_err) ferr_cnt++;
      if (overrun)   ovr_cnt++;
      if (busy)      busy_cnt++;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives len cycles of an 8N1 frame; only a full frame is given to the model.
  task automatic drive_frame(input logic [7:0] d, input bit stop, input int len);
    logic [9:0] bits;
    frame_t     ev;
    bits = {stop, d, 1'b0};
    @(posedge clk);
    #1;
    if (len >= FRAME_CYC) begin
      ev.edge_no = edge_n + LAT;
      ev.data    = d;
      ev.good    = stop;
      evq.push_back(ev);
    end
    for (int c = 0; c < len; c++) begin
      rx_in = bits[c / CPB];
      @(posedge clk);
      #1;
    end
  endtask

  int v0, f0, o0, b0, bd;

  initial begin
    rst      = 1'b1;
    rx_in    = 1'b1;
    rx_ready = 1'b0;
    idle(3);
    check("reset_rx_data", {24'h0, rx_data}, 32'h0);
    check("reset_rx_valid", {31'h0, rx_valid}, 32'h0);
    check("reset_busy", {31'h0, busy}, 32'h0);
    rst = 1'b0;
    idle(5);

    // Single byte with the consumer always ready.
    rx_ready = 1'b1;
    v0 = valid_hi; f0 = ferr_cnt; o0 = ovr_cnt;
    drive_frame(8'hA5, 1'b1, FRAME_CYC);
    idle(4);
    check("t1_data", {24'h0, rx_data}, 32'hA5);
    check("t1_valid_cycles", valid_hi - v0, 32'd1);
    check("t1_valid_low", {31'h0, rx_valid}, 32'h0);
    check("t1_no_ferr", ferr_cnt - f0, 32'd0);
    check("t1_no_ovr", ovr_cnt - o0, 32'd0);
    check("t1_busy_low", {31'h0, busy}, 32'h0);

    // Backpressure: second byte is dropped, first byte held.
    rx_ready = 1'b0;
    o0 = ovr_cnt;
    drive_frame(8'h3C, 1'b1, FRAME_CYC);
    drive_frame(8'h7E, 1'b1, FRAME_CYC);
    idle(4);
    check("t2_data_held", {24'h0, rx_data}, 32'h3C);
    check("t2_valid_held", {31'h0, rx_valid}, 32'h1);
    check("t2_ovr_once", ovr_cnt - o0, 32'd1);
    rx_ready = 1'b1;
    idle(1);
    check("t2_drained", {31'h0, rx_valid}, 32'h0);
    check("t2_data_after", {24'h0, rx_data}, 32'h3C);
    idle(2);

    // Ready raised exactly on the completion edge of the second byte.
    rx_ready = 1'b0;
    drive_frame(8'h11, 1'b1, FRAME_CYC);
    idle(2);
    o0 = ovr_cnt;
    fork
      drive_frame(8'h22, 1'b1, FRAME_CYC);
      begin
        @(posedge clk);
        #1;
        idle(LAT - 1);
        rx_ready = 1'b1;
        idle(1);
        rx_ready = 1'b0;
      end
    join
    idle(2);
    check("t3_data", {24'h0, rx_data}, 32'h22);
    check("t3_valid", {31'h0, rx_valid}, 32'h1);
    check("t3_no_ovr", ovr_cnt - o0, 32'd0);
    rx_ready = 1'b1;
    idle(1);
    check("t3_drained", {31'h0, rx_valid}, 32'h0);

    // Framing error followed by a 40-bit break, then a good byte.
    v0 = valid_hi; f0 = ferr_cnt;
    drive_frame(8'h55, 1'b0, FRAME_CYC);
    idle(40 * CPB);
    rx_in = 1'b1;
    idle(20);
    check("t4_ferr_once", ferr_cnt - f0, 32'd1);
    check("t4_no_valid", valid_hi - v0, 32'd0);
    check("t4_data_kept", {24'h0, rx_data}, 32'h22);
    check("t4_busy_low", {31'h0, busy}, 32'h0);
    drive_frame(8'h0F, 1'b1, FRAME_CYC);
    idle(4);
    check("t4_next_data", {24'h0, rx_data}, 32'h0F);
    check("t4_next_valid", valid_hi - v0, 32'd1);
    check("t4_ferr_still_once", ferr_cnt - f0, 32'd1);

    // Four-cycle glitch is rejected as a false start.
    rx_ready = 1'b0;
    v0 = valid_hi; f0 = ferr_cnt; o0 = ovr_cnt; b0 = busy_cnt;
    idle(1);
    rx_in = 1'b0;
    idle(4);
    rx_in = 1'b1;
    idle(30);
    bd = busy_cnt - b0;
    check("t5_busy_le9", {31'h0, (bd <= 9)}, 32'h1);
    check("t5_busy_seen", {31'h0, (bd > 0)}, 32'h1);
    check("t5_no_valid", valid_hi - v0, 32'd0);
    check("t5_no_ferr", ferr_cnt - f0, 32'd0);
    check("t5_no_ovr", ovr_cnt - o0, 32'd0);
    drive_frame(8'hFF, 1'b1, FRAME_CYC);
    idle(4);
    check("t5_data", {24'h0, rx_data}, 32'hFF);
    check("t5_valid", {31'h0, rx_valid}, 32'h1);

    // Reset during data bit 3 of 0x81, with 0xFF still held.
    drive_frame(8'h81, 1'b1, 4 * CPB + CPB / 2);
    check("t6_busy_before", {31'h0, busy}, 32'h1);
    check("t6_valid_before", {31'h0, rx_valid}, 32'h1);
    rst = 1'b1;
    #1;
    check("t6_rst_data", {24'h0, rx_data}, 32'h0);
    check("t6_rst_valid", {31'h0, rx_valid}, 32'h0);
    check("t6_rst_busy", {31'h0, busy}, 32'h0);
    check("t6_rst_ferr", {31'h0, frame_err}, 32'h0);
    check("t6_rst_ovr", {31'h0, overrun}, 32'h0);
    rx_in = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(3);
    rx_ready = 1'b1;
    v0 = valid_hi; f0 = ferr_cnt; o0 = ovr_cnt;
    drive_frame(8'hC3, 1'b1, FRAME_CYC);
    idle(4);
    check("t6_data", {24'h0, rx_data}, 32'hC3);
    check("t6_valid_cycles", valid_hi - v0, 32'd1);
    check("t6_no_ferr", ferr_cnt - f0, 32'd0);
    check("t6_no_ovr", ovr_cnt - o0, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial 8N1 UART receiver for the FPGA top level: idle-high line, 1 start bit, 8 data bits LSB first, 1 stop bit.
- Feeds the program loader and debug path of the core with one byte at a time.
- Output side is a one-byte holding register with a valid/ready handshake.
- Companion to the stimulus side: benches drive the serial line; this block recovers, checks and buffers the bytes.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per bit (100 MHz / 115200). Legal range is >= 4.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- rx_in  input  1  raw serial line, asynchronous to clk, idle high.
- rx_data  output  8  received byte; valid only while rx_valid=1.
- rx_valid  output  1  holding register full.
- rx_ready  input  1  consumer accepts the byte when rx_valid && rx_ready on a rising edge.
- busy  output  1  high whenever the FSM is not in IDLE.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: completed byte dropped because the holding register was full.

Behaviour:
- Reset values:
  - rx_data=0, rx_valid=0, busy=0, frame_err=0, overrun=0.
  - FSM in IDLE, bit counter 0, clock counter 0.
  - Both synchronizer flops reset to 1.
- Synchronizer:
  - rx_in passes through two flops; the FSM sees only the second stage (rx_s).
  - Falling edge detect compares rx_s with its previous value, also reset to 1.
- Timing convention: in each counted state the clock counter runs 0 to CLKS_PER_BIT-1, then wraps to 0.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE: on a falling edge of rx_s, clear the counter and go to START.
  - START: sample rx_s when the counter = (CLKS_PER_BIT-1)/2 (integer divide).
    - rx_s=1 is a glitch or false start: go to IDLE, no output, no error.
    - rx_s=0: clear the counter and go to DATA with bit index 0. The mid-bit phase is now established.
  - DATA: sample rx_s into shift[bit index] when the counter = CLKS_PER_BIT-1, so every bit is sampled mid-bit.
    - After index 7, go to STOP.
  - STOP: sample rx_s when the counter = CLKS_PER_BIT-1.
    - rx_s=1: byte complete; go to IDLE in the same cycle.
    - rx_s=0: pulse frame_err for one cycle, discard the byte, go to WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s=1, then go to IDLE. A break condition produces exactly one frame_err.
- Byte completion and the handshake, evaluated in the completion cycle:
  - rx_valid=0: load rx_data and set rx_valid on the next edge.
  - rx_valid=1 and rx_ready=1: the old byte transfers and the new byte loads in the same edge. rx_valid stays 1; no overrun.
  - rx_valid=1 and rx_ready=0: the new byte is dropped and the old byte is kept; overrun pulses one cycle.
  - Otherwise, rx_valid && rx_ready clears rx_valid on the next edge. rx_data holds its last value.
- Stability: rx_data and rx_valid never change while rx_valid=1 && rx_ready=0.
- Latency:
  - The byte is visible 1 cycle after the stop-bit sample.
  - That is about 2 synchronizer cycles + (CLKS_PER_BIT-1)/2 + 9*CLKS_PER_BIT + 2 cycles after the rx_in falling edge.
- Back-to-back frames: a start bit right after a good stop is detected, because IDLE is entered at the stop-bit mid-point and the line is high.
- Reset mid-frame: all state returns to reset values immediately (asynchronous). A partially received byte is lost. The next falling edge after deassertion starts a new frame.
- rx_ready while rx_valid=0 is ignored.

Test Plan (CLKS_PER_BIT=16):
- Single byte: drive 0xA5 8N1 with rx_ready=1 → rx_valid pulses one cycle with rx_data=0xA5; frame_err=0, overrun=0; busy=0 afterwards.
- Backpressure and overrun: rx_ready=0, send 0x3C then 0x7E → rx_data stays 0x3C with rx_valid=1; overrun pulses once at the second stop bit. Raising rx_ready then yields 0x3C and rx_valid drops.
- Simultaneous transfer: rx_ready=0 after 0x11; assert rx_ready exactly in the completion cycle of 0x22 → no overrun; rx_data=0x22 next cycle with rx_valid still 1.
- Framing/break: send 0x55 with the stop bit low, hold the line low for 40 bit times, then release → exactly one frame_err pulse, rx_valid stays 0. A following 0x0F is received correctly.
- False start: 4-cycle low glitch on rx_in → FSM returns to IDLE, busy high for at most 9 cycles, no outputs. A subsequent 0xFF is received correctly.
- Reset mid-frame: assert rst during data bit 3 of 0x81 → all outputs are 0 immediately. After release, 0xC3 is received correctly with no error pulses.
